seq_ctrl: RTL

- Parametrised successor to the multicycle CPU state sequencer.
- Generalised behaviour:
  - variable operand-word count per instruction;
  - bus-ready handshake with a wait-state timeout;
  - instruction-boundary interrupt entry;
  - single-step mode.
- Sits in the cpu core between the opcode decoder and the memory bus interface. Its state code drives datapath enables.

---
 rtl/seq_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/seq_ctrl.sv
// seq_ctrl: multicycle CPU state sequencer.
// Operand fetch, bus wait timeout, interrupt entry, single-step.
module seq_ctrl #(
    parameter int OPL_MAX  = 3,
    parameter int WAIT_MAX = 15,
    parameter int WCNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       hlt,
    input  logic       step,
    input  logic       irq,
    input  logic       ie,
    input  logic [2:0] opl_n,
    input  logic       mem_rd,
    input  logic       ld,
    input  logic       bus_rdy,
    output logic [3:0] q,
    output logic [2:0] opl_idx,
    output logic       busy,
    output logic       irq_ack,
    output logic       bus_err
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_OPCFT = 4'd1,
        S_OPLRD = 4'd2,
        S_OPLFT = 4'd3,
        S_ADRD  = 4'd4,
        S_EXERD = 4'd5,
        S_EXE   = 4'd6,
        S_LOAD  = 4'd7,
        S_CHK   = 4'd8,
        S_INTR  = 4'd9,
        S_ERR   = 4'd10
    } state_e;

    localparam logic [2:0]        OPL_MAX_C  = 3'(OPL_MAX);
    localparam logic [WCNT_W-1:0] WAIT_MAX_C = WCNT_W'(WAIT_MAX);
    localparam logic              TMO_EN     = (WAIT_MAX != 0);

    state_e            state_q, state_d;
    logic [2:0]        opl_idx_q, opl_idx_d;
    logic [2:0]        opl_n_q, opl_n_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              irq_ack_q, irq_ack_d;
    logic              bus_err_q, bus_err_d;

    logic [2:0]        opl_clamp;
    logic              wait_st;
    logic              tmo;

    // Operand count clamp and wait-state timeout detection
    always_comb begin
        opl_clamp = (opl_n > OPL_MAX_C) ? OPL_MAX_C : opl_n;
        wait_st   = (state_q == S_OPLRD) || (state_q == S_OPLFT) ||
                    (state_q == S_EXERD) || (state_q == S_LOAD)  ||
                    (state_q == S_INTR);
        tmo       = TMO_EN && wait_st && !bus_rdy &&
                    (wcnt_q == WAIT_MAX_C);
    end

    // Next-state, operand index, wait counter and flag logic
    always_comb begin
        state_d   = state_q;
        opl_idx_d = opl_idx_q;
        opl_n_d   = opl_n_q;
        wcnt_d    = '0;
        irq_ack_d = 1'b0;
        bus_err_d = bus_err_q;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_OPCFT;
            end
            S_OPCFT: begin
                opl_idx_d = '0;
                state_d   = S_OPLRD;
            end
            S_OPLRD: begin
                if (bus_rdy) begin
                    opl_n_d = opl_clamp;
                    state_d = (opl_clamp == 3'd0) ? S_ADRD : S_OPLFT;
                end
            end
            S_OPLFT: begin
                if (bus_rdy) begin
                    if (opl_idx_q == 3'(opl_n_q - 3'd1)) begin
                        state_d = S_ADRD;
                    end else begin
                        opl_idx_d = opl_idx_q + 3'd1;
                    end
                end
            end
            S_ADRD: begin
                state_d = mem_rd ? S_EXERD : S_EXE;
            end
            S_EXERD: begin
                if (bus_rdy) state_d = S_EXE;
            end
            S_EXE: begin
                if (hlt)     state_d = S_IDLE;
                else if (ld) state_d = S_LOAD;
                else         state_d = S_CHK;
            end
            S_LOAD: begin
                if (bus_rdy) state_d = S_CHK;
            end
            S_CHK: begin
                if (irq && ie) state_d = S_INTR;
                else if (step) state_d = S_IDLE;
                else           state_d = S_OPCFT;
            end
            S_INTR: begin
                if (bus_rdy) begin
                    irq_ack_d = 1'b1;
                    state_d   = S_OPCFT;
                end
            end
            S_ERR: begin
                if (!run) begin
                    state_d   = S_IDLE;
                    bus_err_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // bus_rdy in the timeout cycle takes precedence, tmo needs !bus_rdy
        if (tmo) begin
            state_d   = S_ERR;
            bus_err_d = 1'b1;
        end

        // count only consecutive not-ready cycles within one wait state
        if (wait_st && !bus_rdy && (state_d == state_q)) begin
            wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
        end
    end

    // State and datapath registers, asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            opl_idx_q <= '0;
            opl_n_q   <= '0;
            wcnt_q    <= '0;
            irq_ack_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opl_idx_q <= opl_idx_d;
            opl_n_q   <= opl_n_d;
            wcnt_q    <= wcnt_d;
            irq_ack_q <= irq_ack_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign q       = state_q;
    assign opl_idx = opl_idx_q;
    assign busy    = (state_q != S_IDLE);
    assign irq_ack = irq_ack_q;
    assign bus_err = bus_err_q;

endmodule
